// File: rtl/coeff_bank.sv
// Double-buffered coefficient store for an eight-filter bank.
// Eight registered read ports share one word address. A host streams a new
// coefficient set into the shadow bank. The set becomes active only on a
// din_enable strobe, so a swap never lands in the middle of an output computation.
module coeff_bank #(
  parameter int DEPTH  = 64,
  parameter int COEF_W = 18
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [$clog2(DEPTH)-1:0] coeffaddress,
  input  logic                  din_enable,
  output logic [2*COEF_W-1:0]   coeff0,
  output logic [2*COEF_W-1:0]   coeff1,
  output logic [2*COEF_W-1:0]   coeff2,
  output logic [2*COEF_W-1:0]   coeff3,
  output logic [2*COEF_W-1:0]   coeff4,
  output logic [2*COEF_W-1:0]   coeff5,
  output logic [2*COEF_W-1:0]   coeff6,
  output logic [2*COEF_W-1:0]   coeff7,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [COEF_W-1:0]     ld_data,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  active_bank,
  output logic                  bank_valid
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NFILT = 8;
  localparam int CW    = 3 + AW + 1;      // {filter, addr, half}
  localparam int IW    = 1 + 3 + AW;      // {bank, filter, addr}
  localparam int NWORD = 2 * NFILT * DEPTH;

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       ld_cnt;
  logic                xfer;
  logic                last_xfer;
  logic                swap;
  logic [IW-1:0]       wr_idx;

  // Low and high taps live in separate arrays so a half-word write never
  // needs a read-modify-write of the full 36-bit word.
  logic [COEF_W-1:0]   mem_lo [NWORD];
  logic [COEF_W-1:0]   mem_hi [NWORD];

  logic [2*COEF_W-1:0] rd_p1 [NFILT];

  function automatic logic [IW-1:0] rd_idx(input logic bank, input int filt,
                                           input logic [AW-1:0] addr);
    return {bank, 3'(filt), addr};
  endfunction

  // A restart via ld_start takes priority over a transfer in the same cycle.
  assign xfer      = ld_valid && ld_ready && !ld_start;
  assign last_xfer = xfer && (ld_cnt == {CW{1'b1}});
  assign swap      = (state == PEND) && din_enable && !ld_start;
  assign wr_idx    = {~active_bank, ld_cnt[CW-1:1]};

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic; ld_start always restarts the load
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ld_start) state_nxt = LOAD;
      LOAD: begin
        if (ld_start)       state_nxt = LOAD;
        else if (last_xfer) state_nxt = PEND;
      end
      PEND: begin
        if (ld_start)        state_nxt = LOAD;
        else if (din_enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    ld_ready     = (state == LOAD);
    swap_pending = (state == PEND);
  end

  // Load counter: cleared on every ld_start, advanced per accepted tap
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         ld_cnt <= '0;
    else if (ld_start) ld_cnt <= '0;
    else if (xfer)     ld_cnt <= ld_cnt + 1'b1;
  end

  // Bank select, commit flag and the one-cycle swap acknowledge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_bank <= 1'b0;
      bank_valid  <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      swap_done <= swap;
      if (swap) begin
        active_bank <= ~active_bank;
        bank_valid  <= 1'b1;
      end
    end
  end

  // Shadow bank writes; contents are deliberately never cleared
  always_ff @(posedge clock) begin
    if (xfer) begin
      if (ld_cnt[0]) mem_hi[wr_idx] <= ld_data;
      else           mem_lo[wr_idx] <= ld_data;
    end
  end

  // ---- stage p0 -> p1: address in, registered read data out ----
  // Read ports: one-cycle latency from the active bank, zero until committed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NFILT; n++) rd_p1[n] <= '0;
    end else begin
      for (int n = 0; n < NFILT; n++) begin
        if (bank_valid)
          rd_p1[n] <= {mem_hi[rd_idx(active_bank, n, coeffaddress)],
                       mem_lo[rd_idx(active_bank, n, coeffaddress)]};
        else
          rd_p1[n] <= '0;
      end
    end
  end

  assign coeff0 = rd_p1[0];
  assign coeff1 = rd_p1[1];
  assign coeff2 = rd_p1[2];
  assign coeff3 = rd_p1[3];
  assign coeff4 = rd_p1[4];
  assign coeff5 = rd_p1[5];
  assign coeff6 = rd_p1[6];
  assign coeff7 = rd_p1[7];

endmodule

// File: tb/tb_coeff_bank.sv
// Directed bench for coeff_bank: reset state, load/swap, gapped loads,
// swap deferral, restarts and asynchronous reset while a swap is pending.
module tb_coeff_bank;

  logic        clock;
  logic        reset;
  logic [5:0]  coeffaddress;
  logic        din_enable;
  logic [35:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
  logic        ld_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [17:0] ld_data;
  logic        swap_pending;
  logic        swap_done;
  logic        active_bank;
  logic        bank_valid;

  logic [35:0] cf [8];
  int          checks = 0;
  int          errors = 0;
  int          nx;

  coeff_bank dut (
    .clock(clock), .reset(reset), .coeffaddress(coeffaddress),
    .din_enable(din_enable),
    .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .coeff4(coeff4), .coeff5(coeff5), .coeff6(coeff6), .coeff7(coeff7),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .swap_pending(swap_pending), .swap_done(swap_done),
    .active_bank(active_bank), .bank_valid(bank_valid)
  );

  assign cf[0] = coeff0;
  assign cf[1] = coeff1;
  assign cf[2] = coeff2;
  assign cf[3] = coeff3;
  assign cf[4] = coeff4;
  assign cf[5] = coeff5;
  assign cf[6] = coeff6;
  assign cf[7] = coeff7;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tap pattern: {tag, 6'b0, filter, addr, half}; tag 0 is the plain {f,a,h} set
  function automatic logic [17:0] pat(input int tag, input int f, input int a, input int h);
    return {2'(tag), 6'b0, 3'(f), 6'(a), 1'(h)};
  endfunction

  function automatic logic [35:0] word(input int tag, input int f, input int a);
    return {pat(tag, f, a, 1), pat(tag, f, a, 0)};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input int tag, input int a);
    coeffaddress = 6'(a);
    tick();
    for (int n = 0; n < 8; n++)
      chk($sformatf("rd_t%0d_f%0d_a%0d", tag, n, a), cf[n], word(tag, n, a));
  endtask

  task automatic rd_zero(input int a);
    coeffaddress = 6'(a);
    tick();
    for (int n = 0; n < 8; n++)
      chk($sformatf("rdzero_f%0d_a%0d", n, a), cf[n], 36'd0);
  endtask

  // Streams nstop taps of set 'tag'; pct = percent of cycles with ld_valid low.
  // With fin_din, din_enable rides on the 1024th transfer.
  task automatic load(input int tag, input int pct, input int nstop, input bit fin_din,
                      output int nxfer);
    int w;
    int cyc;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    w = 0;
    cyc = 0;
    while (w < nstop && cyc < 20000) begin
      ld_valid = ($urandom_range(0, 99) >= pct);
      if (fin_din && w == 1023) ld_valid = 1'b1;
      din_enable = fin_din && (w == 1023);
      ld_data = pat(tag, w >> 7, (w >> 1) & 63, w & 1);
      if (ld_valid && ld_ready) w++;
      tick();
      cyc++;
    end
    ld_valid   = 1'b0;
    din_enable = 1'b0;
    nxfer = w;
  endtask

  task automatic do_swap(input logic exp_bank);
    din_enable = 1'b1;
    tick();
    din_enable = 1'b0;
    chk("swap_done_hi", swap_done, 1'b1);
    chk("swap_bank", active_bank, exp_bank);
    chk("swap_bank_valid", bank_valid, 1'b1);
    chk("swap_pend_clr", swap_pending, 1'b0);
    tick();
    chk("swap_done_lo", swap_done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; coeffaddress = '0; din_enable = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    tick();
    tick();

    // 1: reset state, reads are zero while no bank is committed
    chk("rst_active_bank", active_bank, 1'b0);
    chk("rst_ld_ready", ld_ready, 1'b0);
    chk("rst_swap_pending", swap_pending, 1'b0);
    chk("rst_swap_done", swap_done, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_zero(5);
      chk("idle_bank_valid", bank_valid, 1'b0);
    end

    // 2: plain load into bank 1, swap on din_enable
    load(0, 0, 1024, 1'b0, nx);
    chk("t2_xfers", 36'(nx), 36'd1024);
    chk("t2_pending", swap_pending, 1'b1);
    chk("t2_ready_drop", ld_ready, 1'b0);
    rd_zero(5);
    do_swap(1'b1);
    coeffaddress = 6'd5;
    tick();
    chk("t2_coeff3_a5", coeff3, {18'd395, 18'd394});
    rd(0, 0);
    rd(0, 63);

    // 3: gapped load (~30% idle) into bank 0
    load(1, 30, 1024, 1'b0, nx);
    chk("t3_xfers", 36'(nx), 36'd1024);
    chk("t3_pending", swap_pending, 1'b1);
    chk("t3_ready_drop", ld_ready, 1'b0);
    rd(0, 5);
    do_swap(1'b0);
    rd(1, 5);
    rd(1, 63);

    // 4: final transfer coincides with din_enable -> no swap yet
    load(2, 10, 1024, 1'b1, nx);
    chk("t4_xfers", 36'(nx), 36'd1024);
    chk("t4_pending", swap_pending, 1'b1);
    chk("t4_no_swap_done", swap_done, 1'b0);
    chk("t4_bank_kept", active_bank, 1'b0);
    rd(1, 12);
    do_swap(1'b1);
    rd(2, 12);

    // 5: set A (tag 2) active; partial set B then full set C restarts
    load(3, 0, 500, 1'b0, nx);
    chk("t5_partial_xfers", 36'(nx), 36'd500);
    chk("t5_still_loading", ld_ready, 1'b1);
    chk("t5_no_pend", swap_pending, 1'b0);
    rd(2, 7);
    load(0, 20, 1024, 1'b0, nx);
    chk("t5_xfers", 36'(nx), 36'd1024);
    chk("t5_pending", swap_pending, 1'b1);
    rd(2, 63);
    do_swap(1'b0);
    rd(0, 5);
    rd(0, 40);

    // ld_start and din_enable together in PEND: restart wins, no swap
    load(3, 0, 1024, 1'b0, nx);
    chk("tb_pending", swap_pending, 1'b1);
    ld_start = 1'b1;
    din_enable = 1'b1;
    tick();
    ld_start = 1'b0;
    din_enable = 1'b0;
    chk("tie_no_swap_done", swap_done, 1'b0);
    chk("tie_reloading", ld_ready, 1'b1);
    chk("tie_pend_clr", swap_pending, 1'b0);
    chk("tie_bank_kept", active_bank, 1'b0);
    tick();
    chk("tie_no_swap_late", swap_done, 1'b0);
    rd(0, 9);

    // 6: bank 1 active, new set pending, then async reset
    load(1, 0, 1024, 1'b0, nx);
    do_swap(1'b1);
    load(3, 0, 1024, 1'b0, nx);
    chk("t6_pending", swap_pending, 1'b1);
    chk("t6_pre_bank", active_bank, 1'b1);
    reset = 1'b1;
    #2;
    chk("t6_async_bank", active_bank, 1'b0);
    chk("t6_async_valid", bank_valid, 1'b0);
    chk("t6_async_pend", swap_pending, 1'b0);
    for (int n = 0; n < 8; n++)
      chk($sformatf("t6_async_coeff%0d", n), cf[n], 36'd0);
    tick();
    reset = 1'b0;
    din_enable = 1'b1;
    tick();
    din_enable = 1'b0;
    chk("t6_no_swap_done", swap_done, 1'b0);
    chk("t6_bank_after", active_bank, 1'b0);
    chk("t6_valid_after", bank_valid, 1'b0);
    rd_zero(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
